// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the four-way light buses: flags bad encodings, conflicts,
// illegal transitions, short dwell and red starvation; latches the first fault and counts green phases.
module traffic_light_monitor #(
    parameter int unsigned MIN_GREEN  = 5,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MAX_RED    = 60,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  north_light,
    input  logic [2:0]  west_light,
    input  logic [2:0]  south_light,
    input  logic [2:0]  east_light,
    input  logic        fault_clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  fault_dir,
    output logic [15:0] phase_count
);

    localparam int unsigned NUM_DIR = 4;
    localparam int unsigned GY_W    = 3;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [CNT_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0] RED_LIMIT = CNT_W'(MAX_RED + 1);
    localparam logic [CNT_W-1:0] MIN_G_L   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_L   = CNT_W'(MIN_YELLOW);

    logic [2:0]       light   [NUM_DIR];
    logic [2:0]       prev_q  [NUM_DIR];
    logic [2:0]       prev_d  [NUM_DIR];
    logic [CNT_W-1:0] dwell_q [NUM_DIR];
    logic [CNT_W-1:0] dwell_d [NUM_DIR];
    logic             armed_q;

    logic [NUM_DIR-1:0] enc_err, non_red, trans_err, short_g, short_y, starve, g_to_y;
    logic [NUM_DIR-1:0] chk_en;
    logic               conflict;
    logic [GY_W-1:0]    gy_cnt;
    logic               fire;
    logic [2:0]         code_d;
    logic [1:0]         dir_d;

    function automatic logic [1:0] lowest_dir(input logic [NUM_DIR-1:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        light[0] = north_light;
        light[1] = west_light;
        light[2] = south_light;
        light[3] = east_light;
    end

    // Per-direction dwell tracking and check evaluation
    always_comb begin
        enc_err   = '0;
        non_red   = '0;
        trans_err = '0;
        short_g   = '0;
        short_y   = '0;
        starve    = '0;
        g_to_y    = '0;
        chk_en    = '0;
        for (int unsigned d = 0; d < NUM_DIR; d++) begin
            prev_d[d]  = prev_q[d];
            dwell_d[d] = dwell_q[d];
            enc_err[d] = !((light[d] == RED) || (light[d] == YEL) || (light[d] == GRN));
            non_red[d] = (light[d] == GRN) || (light[d] == YEL);
            if (!enc_err[d]) begin
                prev_d[d] = light[d];
                if (!armed_q || (light[d] != prev_q[d])) begin
                    dwell_d[d] = CNT_W'(1);
                end else if (dwell_q[d] != DWELL_MAX) begin
                    dwell_d[d] = dwell_q[d] + CNT_W'(1);
                end
            end
            chk_en[d]    = !enc_err[d] && armed_q && (light[d] != prev_q[d]);
            trans_err[d] = chk_en[d] &&
                           !(((prev_q[d] == RED) && (light[d] == GRN)) ||
                             ((prev_q[d] == GRN) && (light[d] == YEL)) ||
                             ((prev_q[d] == YEL) && (light[d] == RED)));
            short_g[d]   = chk_en[d] && (prev_q[d] == GRN) && (dwell_q[d] < MIN_G_L);
            short_y[d]   = chk_en[d] && (prev_q[d] == YEL) && (dwell_q[d] < MIN_Y_L);
            g_to_y[d]    = chk_en[d] && (prev_q[d] == GRN) && (light[d] == YEL);
            // Edge on reaching the limit so a saturated counter cannot refire
            starve[d]    = !enc_err[d] && (light[d] == RED) &&
                           (dwell_d[d] == RED_LIMIT) && (dwell_q[d] != RED_LIMIT);
        end
    end

    always_comb begin
        conflict = ($countones(non_red) > 1);
        gy_cnt   = '0;
        for (int unsigned d = 0; d < NUM_DIR; d++) begin
            gy_cnt = gy_cnt + GY_W'(g_to_y[d]);
        end
    end

    // Lowest code wins, then lowest direction within that code
    always_comb begin
        fire   = 1'b1;
        code_d = 3'd0;
        dir_d  = 2'd0;
        if (|enc_err) begin
            code_d = 3'd1;
            dir_d  = lowest_dir(enc_err);
        end else if (conflict) begin
            code_d = 3'd2;
            dir_d  = lowest_dir(non_red);
        end else if (|trans_err) begin
            code_d = 3'd3;
            dir_d  = lowest_dir(trans_err);
        end else if (|short_g) begin
            code_d = 3'd4;
            dir_d  = lowest_dir(short_g);
        end else if (|short_y) begin
            code_d = 3'd5;
            dir_d  = lowest_dir(short_y);
        end else if (|starve) begin
            code_d = 3'd6;
            dir_d  = lowest_dir(starve);
        end else begin
            fire = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q     <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            fault_dir   <= 2'd0;
            phase_count <= 16'd0;
            for (int unsigned d = 0; d < NUM_DIR; d++) begin
                prev_q[d]  <= RED;
                dwell_q[d] <= '0;
            end
        end else begin
            armed_q     <= 1'b1;
            phase_count <= phase_count + 16'(gy_cnt);
            for (int unsigned d = 0; d < NUM_DIR; d++) begin
                prev_q[d]  <= prev_d[d];
                dwell_q[d] <= dwell_d[d];
            end
            // A new detection takes precedence over a simultaneous clear
            if (fire && (!fault || fault_clr)) begin
                fault      <= 1'b1;
                fault_code <= code_d;
                fault_dir  <= dir_d;
            end else if (fault_clr) begin
                fault      <= 1'b0;
                fault_code <= 3'd0;
                fault_dir  <= 2'd0;
            end
        end
    end

endmodule
